psum_bank: RTL and testbench

Parametrised partial-sum accumulator bank for the ReLU layer. Each of NODES lanes is loaded with a bias, accumulates exactly TERMS signed weighted-input words under a valid/ready handshake, then presents the completed sums until the downstream ReLU stage accepts them. It generalises the fixed-width pStore with configurable lane count, term count and widths. It adds input/output flow control, per-lane overflow flags and an optional saturating mode.

---
 rtl/psum_bank_pkg.sv | 24 ++
 rtl/psum_lane.sv | 80 ++++++++
 rtl/psum_bank.sv | 123 ++++++++++++
 tb/tb_psum_bank.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_bank_pkg.sv
// Shared types and default sizing for the partial-sum accumulator bank.
// Defaults follow the ReLU node count and layer-1 datapath widths.
package psum_bank_pkg;

    typedef enum logic [1:0] {
        PsumIdle = 2'd0,
        PsumAcc  = 2'd1,
        PsumOut  = 2'd2
    } psum_state_e;

    // Per-lane operation issued by the bank controller each cycle.
    typedef enum logic [1:0] {
        LaneHold  = 2'd0,
        LaneClear = 2'd1,
        LaneLoad  = 2'd2,
        LaneAdd   = 2'd3
    } lane_op_e;

    localparam int unsigned RELU_NODES    = 4;
    localparam int unsigned LAYER_1_IN_W  = 8;
    localparam int unsigned LAYER_1_OUT_W = 16;
    localparam int unsigned LAYER_1_TERMS = 16;

endpackage

// File: rtl/psum_lane.sv
// Single accumulator lane: sign-extended bias load, add, sticky overflow.
// PSUM_SATURATE_EN selects clamping on overflow; otherwise the lane wraps.
module psum_lane
    import psum_bank_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [1:0]       op,
    input  logic [IN_W-1:0]  bias,
    input  logic [IN_W-1:0]  weight,
    output logic [OUT_W-1:0] sum,
    output logic             ovf
);

`ifdef PSUM_SATURATE_EN
    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
`endif

    lane_op_e                op_e;
    logic signed [IN_W-1:0]  bias_s;
    logic signed [IN_W-1:0]  weight_s;
    logic signed [OUT_W-1:0] acc_q;
    logic signed [OUT_W-1:0] acc_d;
    logic signed [OUT_W:0]   wide;
    logic                    ovf_q;
    logic                    ovf_d;
    logic                    step_ovf;

    assign op_e     = lane_op_e'(op);
    assign bias_s   = bias;
    assign weight_s = weight;

    // One guard bit: the sum left the OUT_W range when the top two bits differ.
    assign wide     = (OUT_W+1)'(acc_q) + (OUT_W+1)'(weight_s);
    assign step_ovf = wide[OUT_W] ^ wide[OUT_W-1];

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        unique case (op_e)
            LaneClear: begin
                acc_d = '0;
                ovf_d = 1'b0;
            end
            LaneLoad: begin
                acc_d = OUT_W'(bias_s);
                ovf_d = 1'b0;
            end
            LaneAdd: begin
                acc_d = wide[OUT_W-1:0];
                if (step_ovf) begin
                    ovf_d = 1'b1;
`ifdef PSUM_SATURATE_EN
                    acc_d = wide[OUT_W] ? SAT_MIN : SAT_MAX;
`endif
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum = acc_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/psum_bank.sv
// Partial-sum accumulator bank: bias load, TERMS-word accumulation, held output.
// Define PSUM_SATURATE_EN to make every lane saturate instead of wrapping.
module psum_bank
    import psum_bank_pkg::*;
#(
    parameter int unsigned NODES = RELU_NODES,
    parameter int unsigned IN_W  = LAYER_1_IN_W,
    parameter int unsigned OUT_W = LAYER_1_OUT_W,
    parameter int unsigned TERMS = LAYER_1_TERMS
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   flush,
    input  logic                   bias_valid,
    input  logic [NODES*IN_W-1:0]  bias_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NODES*IN_W-1:0]  weights_in,
    output logic                   sum_valid,
    input  logic                   sum_ready,
    output logic [NODES*OUT_W-1:0] sum_out,
    output logic [NODES-1:0]       ovf,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(TERMS + 1);

    psum_state_e      state_q;
    psum_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;
    logic             last_word;
    logic             load;
    lane_op_e         lane_op;

    // Handshake outputs depend on registered state only.
    assign in_ready  = (state_q == PsumAcc);
    assign sum_valid = (state_q == PsumOut);
    assign busy      = (state_q != PsumIdle);

    assign accept    = in_valid & in_ready & ~flush;
    assign last_word = accept & (cnt_q == CNT_W'(TERMS - 1));
    assign load      = ~flush & bias_valid &
                       ((state_q == PsumIdle) | ((state_q == PsumOut) & sum_ready));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = PsumIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                PsumIdle: begin
                    if (bias_valid) begin
                        state_d = PsumAcc;
                        cnt_d   = '0;
                    end
                end
                PsumAcc: begin
                    if (accept) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (last_word) begin
                            state_d = PsumOut;
                        end
                    end
                end
                PsumOut: begin
                    if (sum_ready) begin
                        if (bias_valid) begin
                            state_d = PsumAcc;
                            cnt_d   = '0;
                        end else begin
                            state_d = PsumIdle;
                        end
                    end
                end
                default: begin
                    state_d = PsumIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        lane_op = LaneHold;
        if (flush) begin
            lane_op = LaneClear;
        end else if (load) begin
            lane_op = LaneLoad;
        end else if (accept) begin
            lane_op = LaneAdd;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= PsumIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar i = 0; i < NODES; i++) begin : g_lane
        psum_lane #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk    (clk),
            .clr_n  (clr_n),
            .op     (lane_op),
            .bias   (bias_in[i*IN_W +: IN_W]),
            .weight (weights_in[i*IN_W +: IN_W]),
            .sum    (sum_out[i*OUT_W +: OUT_W]),
            .ovf    (ovf[i])
        );
    end

endmodule

// File: tb/tb_psum_bank.sv
// Scoreboard bench: two psum_bank instances (12-bit and 9-bit lanes) share one
// randomized stimulus stream; a forked monitor checks each completed sum.
module tb_psum_bank;

    localparam int NODES = 2;
    localparam int IN_W  = 8;
    localparam int TERMS = 3;
    localparam int OW_A  = 12;
    localparam int OW_B  = 9;

    typedef struct packed {
        logic [NODES*OW_A-1:0] sum;
        logic [NODES-1:0]      ovf;
    } exp_a_t;

    typedef struct packed {
        logic [NODES*OW_B-1:0] sum;
        logic [NODES-1:0]      ovf;
    } exp_b_t;

    logic                  clk = 1'b0;
    logic                  clr_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  bias_valid = 1'b0;
    logic [NODES*IN_W-1:0] bias_in = '0;
    logic                  in_valid = 1'b0;
    logic [NODES*IN_W-1:0] weights_in = '0;
    logic                  sum_ready = 1'b0;

    logic                  in_ready_a, sum_valid_a, busy_a;
    logic [NODES*OW_A-1:0] sum_out_a;
    logic [NODES-1:0]      ovf_a;
    logic                  in_ready_b, sum_valid_b, busy_b;
    logic [NODES*OW_B-1:0] sum_out_b;
    logic [NODES-1:0]      ovf_b;

    exp_a_t q_a[$];
    exp_b_t q_b[$];
    int     tests = 0;
    int     fails = 0;

    always #5 clk = ~clk;

    psum_bank #(.NODES(NODES), .IN_W(IN_W), .OUT_W(OW_A), .TERMS(TERMS)) dut_a (
        .clk(clk), .clr_n(clr_n), .flush(flush), .bias_valid(bias_valid), .bias_in(bias_in),
        .in_valid(in_valid), .in_ready(in_ready_a), .weights_in(weights_in),
        .sum_valid(sum_valid_a), .sum_ready(sum_ready), .sum_out(sum_out_a), .ovf(ovf_a),
        .busy(busy_a)
    );

    psum_bank #(.NODES(NODES), .IN_W(IN_W), .OUT_W(OW_B), .TERMS(TERMS)) dut_b (
        .clk(clk), .clr_n(clr_n), .flush(flush), .bias_valid(bias_valid), .bias_in(bias_in),
        .in_valid(in_valid), .in_ready(in_ready_b), .weights_in(weights_in),
        .sum_valid(sum_valid_b), .sum_ready(sum_ready), .sum_out(sum_out_b), .ovf(ovf_b),
        .busy(busy_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: integer running sum, clamped or wrapped whenever it leaves the range.
    function automatic void ref_lane(input int out_w, input int b, input int w[TERMS],
                                     output int s, output bit o);
        int hi;
        int lo;
        hi = (1 << (out_w - 1)) - 1;
        lo = -(1 << (out_w - 1));
        s  = b;
        o  = 1'b0;
        for (int k = 0; k < TERMS; k++) begin
            s = s + w[k];
            if (s > hi || s < lo) begin
                o = 1'b1;
`ifdef PSUM_SATURATE_EN
                s = (s > hi) ? hi : lo;
`else
                s = (s > hi) ? s - (1 << out_w) : s + (1 << out_w);
`endif
            end
        end
    endfunction

    task automatic push_expected(input logic [NODES*IN_W-1:0] b,
                                 input logic [NODES*IN_W-1:0] ws[TERMS]);
        exp_a_t ea;
        exp_b_t eb;
        int     w[TERMS];
        int     bi;
        int     s;
        bit     o;
        for (int i = 0; i < NODES; i++) begin
            bi = int'($signed(b[i*IN_W +: IN_W]));
            for (int k = 0; k < TERMS; k++) w[k] = int'($signed(ws[k][i*IN_W +: IN_W]));
            ref_lane(OW_A, bi, w, s, o);
            ea.sum[i*OW_A +: OW_A] = OW_A'(s);
            ea.ovf[i] = o;
            ref_lane(OW_B, bi, w, s, o);
            eb.sum[i*OW_B +: OW_B] = OW_B'(s);
            eb.ovf[i] = o;
        end
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    task automatic monitor();
        exp_a_t ea;
        exp_b_t eb;
        forever begin
            @(negedge clk);
            if (clr_n && sum_ready && sum_valid_a) begin
                if (q_a.size() == 0) chk("unexpected_sum_a", 1, 0);
                else begin
                    ea = q_a.pop_front();
                    chk("sum_a", sum_out_a, ea.sum);
                    chk("ovf_a", ovf_a, ea.ovf);
                end
            end
            if (clr_n && sum_ready && sum_valid_b) begin
                if (q_b.size() == 0) chk("unexpected_sum_b", 1, 0);
                else begin
                    eb = q_b.pop_front();
                    chk("sum_b", sum_out_b, eb.sum);
                    chk("ovf_b", ovf_b, eb.ovf);
                end
            end
        end
    endtask

    task automatic load_bias(input logic [NODES*IN_W-1:0] b);
        bias_valid = 1'b1;
        bias_in    = b;
        @(posedge clk); #1;
        bias_valid = 1'b0;
        @(negedge clk);
        chk("load_in_ready_a", in_ready_a, 1);
        chk("load_in_ready_b", in_ready_b, 1);
    endtask

    // Present n words with random gaps; a full set pushes the expected sum.
    task automatic feed(input logic [NODES*IN_W-1:0] b, input logic [NODES*IN_W-1:0] ws[TERMS],
                        input int n, input bit poke);
        bit got;
        int bnd;
        for (int k = 0; k < n; k++) begin
            if (poke && k == 1) begin
                bias_valid = 1'b1;
                bias_in    = 16'($urandom);
                in_valid   = 1'b0;
                @(posedge clk); #1;
                bias_valid = 1'b0;
            end
            for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
                in_valid   = 1'b0;
                weights_in = 16'($urandom);
                @(posedge clk); #1;
            end
            in_valid   = 1'b1;
            weights_in = ws[k];
            bnd        = 0;
            forever begin
                got = in_ready_a;
                @(posedge clk); #1;
                if (got) break;
                bnd++;
                if (bnd > 20) begin
                    chk("accept_timeout", 0, 1);
                    break;
                end
            end
        end
        in_valid = 1'b0;
        if (n == TERMS) begin
            push_expected(b, ws);
            @(negedge clk);
            chk("latency_sum_valid_a", sum_valid_a, 1);
            chk("latency_sum_valid_b", sum_valid_b, 1);
            chk("out_in_ready_a", in_ready_a, 0);
        end
    endtask

    task automatic drain(input int delay, input bit b2b, input logic [NODES*IN_W-1:0] nb);
        @(posedge clk); #1;
        for (int d = 0; d < delay; d++) begin
            @(posedge clk); #1;
        end
        sum_ready  = 1'b1;
        bias_valid = b2b;
        bias_in    = nb;
        @(posedge clk); #1;
        sum_ready  = 1'b0;
        bias_valid = 1'b0;
        @(negedge clk);
        chk("drain_sum_valid", sum_valid_a, 0);
        chk("drain_in_ready", in_ready_a, b2b);
        chk("drain_busy", busy_a, b2b);
        chk("drain_busy_b", busy_b, b2b);
    endtask

    initial begin
        logic [NODES*IN_W-1:0] ws[TERMS];
        logic [NODES*IN_W-1:0] cur;
        logic [NODES*IN_W-1:0] nb;
        logic [OW_B-1:0]       ovf_exp;
        bit                    loaded;
        bit                    b2b;

        fork
            monitor();
            begin
                #200000;
                chk("watchdog", 0, 1);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        join_none

        // Reset state
        #3;
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_sum_valid", sum_valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_sum_out", sum_out_a, 0);
        chk("rst_ovf", ovf_a, 0);
        @(posedge clk); #1;
        clr_n = 1'b1;

        // Basic sum, then back-pressure with in_valid held high
        ws[0] = 16'h5A5A; ws[1] = 16'hF9F9; ws[2] = 16'h0101;
        load_bias(16'hFA05);
        feed(16'hFA05, ws, TERMS, 1'b0);
        chk("basic_sum_a", sum_out_a, {12'd78, 12'd89});
        chk("basic_ovf_a", ovf_a, 0);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            weights_in = 16'($urandom);
            @(negedge clk);
            chk("bp_sum_stable", sum_out_a, {12'd78, 12'd89});
            chk("bp_in_ready", in_ready_a, 0);
            chk("bp_sum_valid", sum_valid_a, 1);
        end
        in_valid = 1'b0;
        drain(0, 1'b0, 16'h0);

        // Overflow on the 9-bit instance
        ws[0] = 16'h7F7F; ws[1] = 16'h7F7F; ws[2] = 16'h7F7F;
        load_bias(16'h7F7F);
        feed(16'h7F7F, ws, TERMS, 1'b0);
`ifdef PSUM_SATURATE_EN
        ovf_exp = 9'd255;
`else
        ovf_exp = 9'h1FC;
`endif
        chk("ovf_sum_b", sum_out_b, {ovf_exp, ovf_exp});
        chk("ovf_flag_b", ovf_b, 2'b11);
        chk("no_ovf_sum_a", sum_out_a, {12'd508, 12'd508});
        drain(1, 1'b0, 16'h0);

        // Flush after two accepts, with a word presented alongside
        for (int k = 0; k < TERMS; k++) ws[k] = 16'($urandom);
        load_bias(16'h1234);
        feed(16'h1234, ws, 2, 1'b0);
        flush      = 1'b1;
        in_valid   = 1'b1;
        weights_in = 16'($urandom);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("flush_in_ready", in_ready_a, 0);
            chk("flush_busy", busy_a, 0);
            chk("flush_sum_valid", sum_valid_b, 0);
        end

        // Asynchronous reset mid-accumulation
        load_bias(16'h0F0F);
        feed(16'h0F0F, ws, 1, 1'b0);
        #2 clr_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready_a, 0);
        chk("arst_busy", busy_b, 0);
        chk("arst_sum_valid", sum_valid_a, 0);
        chk("arst_sum_out", sum_out_a, 0);
        chk("arst_ovf", ovf_b, 0);
        @(posedge clk); #1;
        clr_n = 1'b1;

        // Randomized sums: gaps, ignored bias pokes, back-pressure, back-to-back loads
        loaded = 1'b0;
        cur    = 16'($urandom);
        for (int t = 0; t < 40; t++) begin
            if (!loaded) load_bias(cur);
            for (int k = 0; k < TERMS; k++) ws[k] = 16'($urandom);
            feed(cur, ws, TERMS, ($urandom_range(0, 3) == 0));
            nb  = 16'($urandom);
            b2b = 1'($urandom_range(0, 1));
            drain($urandom_range(0, 3), b2b, nb);
            loaded = b2b;
            cur    = b2b ? nb : 16'($urandom);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_a_empty", q_a.size(), 0);
        chk("queue_b_empty", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
